// File: rtl/rx_receiver.sv
// rx_receiver: 16x-oversampled asynchronous serial receiver with 5..8 data
// bits, 1 or 2 stop bits, a one-word holding register with valid, frame-error
// and overrun flags.
// Optional feature: define RX_CFG_DETECT_EN to add a 10 ms line-low detector
// that pulses config_req_slv_o and aborts any frame in progress.

`ifndef SYSTEM_CLOCK_FREQ
`define SYSTEM_CLOCK_FREQ 50_000_000
`endif

module rx_receiver #(
    parameter int CLK_FREQ_HZ = `SYSTEM_CLOCK_FREQ
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ov_baud_rt_i,
    input  logic       rx_i,
    input  logic [1:0] data_width_i,
    input  logic [1:0] stop_bits_number_i,
    input  logic       rx_read_i,
    output logic [7:0] data_rx_o,
    output logic       rx_valid_o,
    output logic       rx_done_o,
    output logic       frame_error_o,
    output logic       overrun_o,
    output logic       config_req_slv_o
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // A 10 ms window cannot be measured with fewer than 100 clocks per second.
    if (CLK_FREQ_HZ < 100) begin : g_clk_freq_check
        $error("rx_receiver: CLK_FREQ_HZ must be at least 100");
    end

    state_t     state, state_nxt;
    logic [3:0] tick_cnt, tick_cnt_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic [1:0] width_q, width_nxt;       // data width captured for this frame
    logic       two_stop_q, two_stop_nxt; // stop-bit count captured for this frame
    logic       stop_idx, stop_idx_nxt;   // 0 = first stop bit, 1 = second
    logic       err_q, err_nxt;           // a stop bit of this frame was low
    logic       load_q, load_nxt;         // final stop sampled: publish next cycle

    logic       rx_s1, rx_s2, rx_s3;
    logic       fall;
    logic       abort;
    logic [2:0] last_bit;

    assign fall     = rx_s3 & ~rx_s2;
    assign last_bit = 3'd4 + {1'b0, width_q};

    // Two-flop synchronizer plus one extra stage for falling-edge detection.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours; blocking here would
        // collapse the synchronizer chain into a single flop.
        if (rst_i) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx_i;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

`ifdef RX_CFG_DETECT_EN
    localparam int LOW_LIMIT = CLK_FREQ_HZ / 100;
    localparam int LOW_W     = $clog2(LOW_LIMIT) + 1;
    localparam logic [LOW_W-1:0] LOW_MAX = LOW_W'(LOW_LIMIT);
    localparam logic [LOW_W-1:0] LOW_PRE = LOW_W'(LOW_LIMIT - 1);
    localparam logic [LOW_W-1:0] LOW_ONE = LOW_W'(1);

    logic [LOW_W-1:0] low_cnt;
    logic             cfg_hit;

    // The counter saturates at the limit, so the hit fires once per low period.
    assign cfg_hit = ~rx_s2 & (low_cnt == LOW_PRE);
    assign abort   = cfg_hit;

    // Measure how long the synchronized line has been low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            low_cnt          <= '0;
            config_req_slv_o <= 1'b0;
        end else begin
            config_req_slv_o <= cfg_hit;
            if (rx_s2) begin
                low_cnt <= '0;
            end else if (low_cnt != LOW_MAX) begin
                low_cnt <= low_cnt + LOW_ONE;
            end
        end
    end
`else
    assign abort            = 1'b0;
    assign config_req_slv_o = 1'b0;
`endif

    // Frame FSM state and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            width_q    <= '0;
            two_stop_q <= 1'b0;
            stop_idx   <= 1'b0;
            err_q      <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            tick_cnt   <= tick_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            width_q    <= width_nxt;
            two_stop_q <= two_stop_nxt;
            stop_idx   <= stop_idx_nxt;
            err_q      <= err_nxt;
            load_q     <= load_nxt;
        end
    end

    // Next-state logic: sample mid-start, then every 16th tick for data and stop.
    always_comb begin
        // NOTE: every signal gets a default before the case statement; a path
        // that leaves one unassigned would infer a latch.
        state_nxt    = state;
        tick_cnt_nxt = tick_cnt;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        width_nxt    = width_q;
        two_stop_nxt = two_stop_q;
        stop_idx_nxt = stop_idx;
        err_nxt      = err_q;
        load_nxt     = 1'b0;

        unique case (state)
            IDLE: begin
                tick_cnt_nxt = '0;
                if (fall) begin
                    state_nxt    = START;
                    bit_cnt_nxt  = '0;
                    stop_idx_nxt = 1'b0;
                    err_nxt      = 1'b0;
                end
            end
            START: begin
                if (ov_baud_rt_i) begin
                    if (tick_cnt == 4'd7) begin
                        tick_cnt_nxt = '0;
                        if (!rx_s2) begin
                            state_nxt    = DATA;
                            width_nxt    = data_width_i;
                            two_stop_nxt = (stop_bits_number_i == 2'b01);
                        end else begin
                            state_nxt = IDLE;   // glitch: start bit not low at mid-bit
                        end
                    end else begin
                        tick_cnt_nxt = tick_cnt + 4'd1;
                    end
                end
            end
            DATA: begin
                if (ov_baud_rt_i) begin
                    tick_cnt_nxt = tick_cnt + 4'd1;   // wraps 15 -> 0 each bit
                    if (tick_cnt == 4'd15) begin
                        shreg_nxt   = {rx_s2, shreg[7:1]};
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == last_bit) begin
                            state_nxt = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (ov_baud_rt_i) begin
                    tick_cnt_nxt = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        if (!rx_s2) begin
                            err_nxt = 1'b1;
                        end
                        if (two_stop_q && !stop_idx) begin
                            stop_idx_nxt = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            load_nxt  = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (abort) begin
            state_nxt    = IDLE;
            tick_cnt_nxt = '0;
        end
    end

    // Holding register and status flags seen by the consumer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_rx_o     <= '0;
            rx_valid_o    <= 1'b0;
            rx_done_o     <= 1'b0;
            frame_error_o <= 1'b0;
            overrun_o     <= 1'b0;
        end else begin
            rx_done_o <= load_q;
            if (load_q) begin
                data_rx_o     <= shreg >> (2'd3 - width_q);
                rx_valid_o    <= 1'b1;
                frame_error_o <= err_q;
                if (rx_valid_o && !rx_read_i) begin
                    overrun_o <= 1'b1;
                end else if (rx_valid_o && rx_read_i) begin
                    overrun_o <= 1'b0;
                end
            end else if (rx_read_i && rx_valid_o) begin
                rx_valid_o    <= 1'b0;
                frame_error_o <= 1'b0;
                overrun_o     <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rx_receiver.md
RX_RECEIVER -- requirements
Module: rx_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default SYSTEM_CLOCK_FREQ, system clock frequency used for the 10 ms line-low timeout.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port ov_baud_rt_i, input, 1 bit: one-cycle tick at 16x the baud rate.
REQ-005 SHALL have port rx_i, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port data_width_i, input, 2 bits: 00=5, 01=6, 10=7, 11=8 data bits.
REQ-007 SHALL have port stop_bits_number_i, input, 2 bits: 01=2 stop bits; every other value=1 stop bit.
REQ-008 SHALL have port rx_read_i, input, 1 bit: consumer acknowledges data_rx_o.
REQ-009 SHALL have port data_rx_o, output, 8 bits: received word, right-aligned, unused upper bits 0.
REQ-010 SHALL have port rx_valid_o, output, 1 bit: data_rx_o holds an unread word.
REQ-011 SHALL have port rx_done_o, output, 1 bit: one-cycle pulse per completed frame.
REQ-012 SHALL have port frame_error_o, output, 1 bit: the held word had a stop bit sampled low.
REQ-013 SHALL have port overrun_o, output, 1 bit: sticky flag; a word arrived while rx_valid_o=1 and no read occurred.
REQ-014 SHALL have port config_req_slv_o, output, 1 bit: one-cycle pulse when the line has been low for 10 ms.

Function
REQ-015 SHALL pass rx_i through a 2-flop synchronizer, then a third registered sample used for edge detection.
REQ-016 SHALL use FSM states IDLE, START, DATA and STOP, and a 4-bit tick counter advanced only on ov_baud_rt_i.
REQ-017 IDLE SHALL go to START on a synchronized high-to-low edge; a line that is merely low SHALL NOT trigger a start.
REQ-018 START SHALL sample the line on the 8th tick (mid-bit): low -> DATA with counter cleared; high -> IDLE as a glitch, with no outputs changed.
REQ-019 DATA SHALL sample every 16th tick and shift the sample into bit 7 of an 8-bit register (LSB first on the wire), for 5/6/7/8 bits per data_width_i.
REQ-020 STOP SHALL sample every 16th tick, once or twice per stop_bits_number_i; any low sample SHALL mark a frame error.
REQ-021 One cycle after the final stop sample, SHALL load data_rx_o = shift register >> (8 - width), set rx_valid_o=1, set frame_error_o to the frame's error status, pulse rx_done_o, and return to IDLE.
REQ-022 rx_read_i while rx_valid_o=1 SHALL clear rx_valid_o and frame_error_o on the next cycle; rx_read_i while rx_valid_o=0 SHALL be ignored.
REQ-023 A load while rx_valid_o=1 without rx_read_i in the same cycle SHALL overwrite the word and set overrun_o; overrun_o SHALL clear on the cycle after rx_read_i.
REQ-024 A load and rx_read_i in the same cycle SHALL leave rx_valid_o=1 with the new word and SHALL NOT set overrun_o.
REQ-025 data_width_i and stop_bits_number_i SHALL be sampled at the START -> DATA transition and held for the rest of the frame.

Reset
REQ-026 On rst_i, SHALL set state IDLE, counters 0, synchronizer flops 1, data_rx_o 0, and rx_valid_o, rx_done_o, frame_error_o, overrun_o, config_req_slv_o all 0.
REQ-027 Reset mid-frame SHALL discard the partial frame, with no rx_done_o pulse after reset releases.

Configuration
REQ-028 With RX_CFG_DETECT_EN defined, a cycle counter (width clog2(CLK_FREQ_HZ/100)+1) SHALL count while the synchronized line is low and clear while it is high.
REQ-029 When that counter reaches CLK_FREQ_HZ/100, SHALL pulse config_req_slv_o once per low period, force the FSM to IDLE, and discard any partial frame.
REQ-030 Without RX_CFG_DETECT_EN, config_req_slv_o SHALL be tied to 0 and the counter SHALL be absent.

Verification (ov_baud_rt_i held at 1, i.e. 16 clocks per bit)
REQ-031 8N1 frame carrying 0xA5 -> data_rx_o=0xA5, rx_valid_o=1, one rx_done_o pulse, frame_error_o=0.
REQ-032 5-bit width, 2 stop bits, frame carrying 0x1B with the second stop bit low -> data_rx_o=0x1B, frame_error_o=1.
REQ-033 rx_i low for 4 clocks, then high -> FSM back in IDLE, no rx_done_o pulse.
REQ-034 Two frames 0x11 then 0x22 with no rx_read_i -> data_rx_o=0x22, overrun_o=1; then rx_read_i -> rx_valid_o=0 and overrun_o=0.
REQ-035 rst_i asserted during DATA bit 3 -> all outputs 0 next cycle; a following 0x3C frame is received correctly.
REQ-036 With RX_CFG_DETECT_EN and CLK_FREQ_HZ=10000, rx_i held low for 150 clocks -> exactly one config_req_slv_o pulse at 100 clocks of synchronized low, and no rx_valid_o.
